umich_seq_div_op: RTL

- Multi-cycle iterative divider for the synthetic-operator simulation library. Produces quotient and remainder for unsigned or two's-complement operands.
- Fills the gap beside the single-cycle add/sub/mult/compare operators. Sits downstream of operand-select muxing and upstream of result registers.
- Uses a valid/ready handshake on both sides, so it can be paced by a controller FSM.

---
 rtl/umich_div_pkg.sv | 23 ++
 rtl/umich_div_step.sv | 27 ++
 rtl/umich_seq_div_op.sv | 131 +++++++++++++
 3 files changed

// File: rtl/umich_div_pkg.sv
// Shared types and helpers for the sequential divider.
//   DEF_WIDTH   : default operand/result width
//   ABS_W       : working width of abs_tc (callers must use WIDTH <= ABS_W)
//   div_state_e : divider FSM states
//   abs_tc      : magnitude of a sign-extended value when tc=1, pass-through otherwise
package umich_div_pkg;

  localparam int unsigned DEF_WIDTH = 64;
  localparam int unsigned ABS_W     = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Negation at ABS_W bits truncates to the same bits as negation at the caller's width.
  function automatic logic [ABS_W-1:0] abs_tc(input logic [ABS_W-1:0] value, input logic tc);
    return (tc && value[ABS_W-1]) ? ABS_W'(-value) : value;
  endfunction

endpackage

// File: rtl/umich_div_step.sv
// One restoring-division step (combinational).
//   rem        : current partial remainder (always < divisor)
//   dvd_bit    : next dividend bit, MSB first
//   divisor    : divisor magnitude
//   rem_next_c : remainder after the step
//   q_bit_c    : quotient bit produced by the step
module umich_div_step #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next_c,
  output logic             q_bit_c
);

  // WIDTH+1 bits so the shifted remainder never overflows the compare.
  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  assign trial      = {rem, dvd_bit};
  assign diff       = trial - {1'b0, divisor};
  assign q_bit_c    = (trial >= {1'b0, divisor});
  // Either result is below the divisor, so the top bit is always zero.
  assign rem_next_c = WIDTH'(q_bit_c ? diff : trial);

endmodule

// File: rtl/umich_seq_div_op.sv
// Multi-cycle restoring divider with valid/ready handshakes.
//   clocked_on : clock, rising edge
//   preset     : asynchronous active-high reset
//   in_valid / in_ready   : operand handshake (A, B, TC)
//   out_valid / out_ready : result handshake (QUOT, REM, DIV0)
//   TC         : 1 = two's-complement operands, 0 = unsigned
module umich_seq_div_op
  import umich_div_pkg::*;
#(
  parameter  int unsigned WIDTH = DEF_WIDTH,
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clocked_on,
  input  logic             preset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             TC,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] QUOT,
  output logic [WIDTH-1:0] REM,
  output logic             DIV0
);

  div_state_e       state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_q;      // raw dividend, returned as REM on divide-by-zero
  logic [WIDTH-1:0] bmag_q;   // divisor magnitude
  logic [WIDTH-1:0] dvd_q;    // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] rem_q;
  logic             qneg_q;
  logic             rneg_q;
  logic             div0_q;

  logic [WIDTH-1:0] a_mag_c;
  logic [WIDTH-1:0] b_mag_c;
  logic             sign_a_c;
  logic             sign_b_c;
  logic             b_zero_c;
  logic [WIDTH-1:0] rem_next_c;
  logic             q_bit_c;

  // Operand magnitudes and signs, only used on the acceptance edge.
  assign sign_a_c = TC & A[WIDTH-1];
  assign sign_b_c = TC & B[WIDTH-1];
  assign b_zero_c = (B == '0);
  assign a_mag_c  = WIDTH'(abs_tc(ABS_W'($signed(A)), TC));
  assign b_mag_c  = WIDTH'(abs_tc(ABS_W'($signed(B)), TC));

  umich_div_step #(.WIDTH(WIDTH)) u_step (
    .rem        (rem_q),
    .dvd_bit    (dvd_q[WIDTH-1]),
    .divisor    (bmag_q),
    .rem_next_c (rem_next_c),
    .q_bit_c    (q_bit_c)
  );

  // State register.
  always_ff @(posedge clocked_on or posedge preset) begin
    if (preset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; divide-by-zero also passes through FIX to register its result.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = b_zero_c ? FIX : CALC;
      CALC: if (cnt == CNT_W'(WIDTH - 1)) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered handshake/result outputs.
  always_ff @(posedge clocked_on or posedge preset) begin
    if (preset) begin
      cnt       <= '0;
      a_q       <= '0;
      bmag_q    <= '0;
      dvd_q     <= '0;
      rem_q     <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      div0_q    <= 1'b0;
      QUOT      <= '0;
      REM       <= '0;
      DIV0      <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (in_valid) begin
            cnt    <= '0;
            a_q    <= A;
            bmag_q <= b_mag_c;
            dvd_q  <= a_mag_c;
            rem_q  <= '0;
            qneg_q <= sign_a_c ^ sign_b_c;
            rneg_q <= sign_a_c;
            div0_q <= b_zero_c;
          end
        end
        CALC: begin
          dvd_q <= {dvd_q[WIDTH-2:0], q_bit_c};
          rem_q <= rem_next_c;
          cnt   <= cnt + CNT_W'(1);
        end
        FIX: begin
          if (div0_q) begin
            QUOT <= '1;
            REM  <= a_q;
            DIV0 <= 1'b1;
          end else begin
            QUOT <= qneg_q ? WIDTH'(-dvd_q) : dvd_q;
            REM  <= rneg_q ? WIDTH'(-rem_q) : rem_q;
            DIV0 <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
